// File: rtl/rz_decode_rx.sv
// WS2812-style RZ line receiver: measures each high pulse, decodes it as a 0 or 1 bit,
// assembles 24-bit words MSB-first and detects the reset-low period that ends a frame.
module rz_decode_rx #(
    parameter int unsigned T0H_MIN  = 10,
    parameter int unsigned TH_SPLIT = 30,
    parameter int unsigned T1H_MAX  = 50,
    parameter int unsigned RST_CNT  = 2500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rz_in,
    output logic [23:0] rgb,
    output logic        rgb_valid,
    output logic        frame_done,
    output logic [15:0] pix_cnt,
    output logic        err,
    output logic        busy
);

    localparam logic [5:0]  T0H_MIN_C  = 6'(T0H_MIN);
    localparam logic [5:0]  TH_SPLIT_C = 6'(TH_SPLIT);
    localparam logic [5:0]  T1H_MAX_C  = 6'(T1H_MAX);
    localparam logic [11:0] RST_C      = 12'(RST_CNT);
    localparam logic [11:0] RST_M1_C   = 12'(RST_CNT - 1);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t      state_q, state_d;
    logic        sync0_q, s1_q, s2_q;
    logic [5:0]  high_cnt_q, high_cnt_d;
    logic [11:0] low_cnt_q, low_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    // Only the 23 earlier bits are stored; the 24th arrives straight into rgb.
    logic [22:0] shift_q, shift_d;
    logic [23:0] rgb_q, rgb_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic        rgb_valid_q, rgb_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic        rise, fall, low_done, bit_val;
    logic [23:0] new_word;

    always_comb begin
        rise       = s1_q & ~s2_q;
        fall       = ~s1_q & s2_q;
        // Registered outputs fire on the edge where low_cnt reaches RST_CNT.
        low_done   = ~s1_q && (low_cnt_q >= RST_M1_C);
        bit_val    = (high_cnt_q > TH_SPLIT_C);
        new_word   = {shift_q, bit_val};
        high_cnt_d = s1_q ? ((high_cnt_q == 6'd63) ? high_cnt_q : high_cnt_q + 6'd1) : 6'd0;
        low_cnt_d  = s1_q ? 12'd0 : ((low_cnt_q == RST_C) ? low_cnt_q : low_cnt_q + 12'd1);
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rgb_d        = rgb_q;
        pix_cnt_d    = pix_cnt_q;
        rgb_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        busy_d       = busy_q;
        case (state_q)
            SYNC: begin
                if (low_done) state_d = IDLE;
            end
            IDLE: begin
                if (rise) begin
                    pix_cnt_d = 16'd0;
                    bit_cnt_d = 5'd0;
                    busy_d    = 1'b1;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if ((s1_q && high_cnt_q > T1H_MAX_C) ||
                    (fall && (high_cnt_q < T0H_MIN_C || high_cnt_q > T1H_MAX_C))) begin
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    bit_cnt_d = 5'd0;
                    state_d   = SYNC;
                end else if (fall) begin
                    shift_d = new_word[22:0];
                    state_d = LOW;
                    if (bit_cnt_q == 5'd23) begin
                        rgb_d       = new_word;
                        rgb_valid_d = 1'b1;
                        pix_cnt_d   = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
                        bit_cnt_d   = 5'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (low_done) begin
                    frame_done_d = 1'b1;
                    err_d        = (bit_cnt_q != 5'd0);
                    busy_d       = 1'b0;
                    bit_cnt_d    = 5'd0;
                    state_d      = IDLE;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SYNC;
            sync0_q      <= 1'b0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            high_cnt_q   <= 6'd0;
            low_cnt_q    <= 12'd0;
            bit_cnt_q    <= 5'd0;
            shift_q      <= 23'd0;
            rgb_q        <= 24'd0;
            pix_cnt_q    <= 16'd0;
            rgb_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync0_q      <= rz_in;
            s1_q         <= sync0_q;
            s2_q         <= s1_q;
            high_cnt_q   <= high_cnt_d;
            low_cnt_q    <= low_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rgb_q        <= rgb_d;
            pix_cnt_q    <= pix_cnt_d;
            rgb_valid_q  <= rgb_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign rgb        = rgb_q;
    assign rgb_valid  = rgb_valid_q;
    assign frame_done = frame_done_q;
    assign pix_cnt    = pix_cnt_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rz_decode_rx.sv
// Directed bench for rz_decode_rx: words and frame results are queued as they are sent
// and popped by a negedge monitor whenever the receiver strobes rgb_valid or frame_done.
module tb_rz_decode_rx;

    localparam int RST_CNT = 2500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rz_in;
    logic [23:0] rgb;
    logic        rgb_valid;
    logic        frame_done;
    logic [15:0] pix_cnt;
    logic        err;
    logic        busy;

    int          n_vectors = 0;
    int          n_miscompares = 0;
    int          cyc = 0;
    int          err_seen = 0;
    int          last_rv_cyc = -1;
    int          last_fd_cyc = -1;
    int          k;
    logic [23:0] rgb_exp_q[$];
    int          fd_pix_q[$];
    bit          fd_err_q[$];

    rz_decode_rx dut (
        .clk(clk),
        .rst_n(rst_n),
        .rz_in(rz_in),
        .rgb(rgb),
        .rgb_valid(rgb_valid),
        .frame_done(frame_done),
        .pix_cnt(pix_cnt),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Level is held for exactly 'cycles' sampling edges; each call ends 1 time unit after an edge.
    task automatic apply_stimulus(input logic level, input int cycles);
        rz_in = level;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pulse(input int high_w, input int low_w);
        apply_stimulus(1'b1, high_w);
        apply_stimulus(1'b0, low_w);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_pulse(40, 22);
        else   send_pulse(20, 42);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rgb_valid) begin
                check_output("rgb_valid_expected", (rgb_exp_q.size() != 0), 1);
                if (rgb_exp_q.size() != 0) check_output("rgb_word", rgb, rgb_exp_q.pop_front());
                last_rv_cyc = cyc;
            end
            if (frame_done) begin
                check_output("frame_done_expected", (fd_pix_q.size() != 0), 1);
                if (fd_pix_q.size() != 0) begin
                    check_output("frame_pix_cnt", pix_cnt, fd_pix_q.pop_front());
                    check_output("frame_err", err, fd_err_q.pop_front());
                end
                last_fd_cyc = cyc;
            end
            if (err) err_seen++;
        end
    end

    initial begin
        rz_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("reset_rgb", rgb, 0);
        check_output("reset_rgb_valid", rgb_valid, 0);
        check_output("reset_frame_done", frame_done, 0);
        check_output("reset_pix_cnt", pix_cnt, 0);
        check_output("reset_err", err, 0);
        check_output("reset_busy", busy, 0);
        @(posedge clk);
        #1;

        $display("[TB] single word 0xA53CF0 with latency checks");
        apply_stimulus(1'b0, 2600);
        rgb_exp_q.push_back(24'hA53CF0);
        fd_pix_q.push_back(1);
        fd_err_q.push_back(1'b0);
        for (int i = 23; i >= 1; i--) send_bit(24'hA53CF0 >> i);
        apply_stimulus(1'b1, 20);
        check_output("busy_mid_frame", busy, 1);
        k = cyc;
        apply_stimulus(1'b0, 2600);
        check_output("rgb_valid_latency", last_rv_cyc - k, 3);
        check_output("frame_done_latency", last_fd_cyc - k, RST_CNT + 2);
        check_output("busy_after_frame", busy, 0);
        check_output("err_count_word1", err_seen, 0);

        $display("[TB] three back-to-back words");
        rgb_exp_q.push_back(24'hFF0000);
        rgb_exp_q.push_back(24'h00FF00);
        rgb_exp_q.push_back(24'h0000FF);
        fd_pix_q.push_back(3);
        fd_err_q.push_back(1'b0);
        send_word(24'hFF0000);
        send_word(24'h00FF00);
        send_word(24'h0000FF);
        apply_stimulus(1'b0, 2600);
        check_output("pix_cnt_three", pix_cnt, 3);
        check_output("rgb_hold_three", rgb, 24'h0000FF);

        $display("[TB] boundary widths 10/30/31/50");
        rgb_exp_q.push_back(24'h333333);
        fd_pix_q.push_back(1);
        fd_err_q.push_back(1'b0);
        for (int r = 0; r < 6; r++) begin
            send_pulse(10, 1);
            send_pulse(30, 5);
            send_pulse(31, 5);
            send_pulse(50, 5);
        end
        apply_stimulus(1'b0, 2600);
        check_output("err_count_boundary", err_seen, 0);

        $display("[TB] too-short and too-long highs");
        send_pulse(9, 30);
        check_output("err_count_short", err_seen, 1);
        check_output("busy_after_short", busy, 0);
        send_word(24'h555555);
        apply_stimulus(1'b0, 2600);
        send_pulse(51, 30);
        check_output("err_count_long", err_seen, 2);
        send_word(24'hAAAAAA);
        apply_stimulus(1'b0, 2600);
        check_output("rgb_hold_after_err", rgb, 24'h333333);

        $display("[TB] partial word at frame end");
        fd_pix_q.push_back(0);
        fd_err_q.push_back(1'b1);
        for (int i = 11; i >= 0; i--) send_bit(12'hABC >> i);
        apply_stimulus(1'b0, 2600);
        check_output("err_count_partial", err_seen, 3);
        check_output("rgb_hold_partial", rgb, 24'h333333);

        $display("[TB] reset released mid-stream");
        apply_stimulus(1'b1, 15);
        rst_n = 1'b0;
        apply_stimulus(1'b0, 20);
        apply_stimulus(1'b1, 30);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 10);
        apply_stimulus(1'b0, 22);
        send_word(24'h5A5A5A);
        send_word(24'hC3C3C3);
        apply_stimulus(1'b0, 2600);
        rgb_exp_q.push_back(24'h123456);
        fd_pix_q.push_back(1);
        fd_err_q.push_back(1'b0);
        send_word(24'h123456);
        apply_stimulus(1'b0, 2600);
        check_output("rgb_after_resync", rgb, 24'h123456);
        check_output("err_count_resync", err_seen, 3);

        $display("[TB] reset asserted during bit 15");
        for (int i = 23; i >= 9; i--) send_bit(24'h00FFFF >> i);
        apply_stimulus(1'b1, 5);
        check_output("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check_output("midreset_rgb", rgb, 0);
        check_output("midreset_pix_cnt", pix_cnt, 0);
        check_output("midreset_busy", busy, 0);
        check_output("midreset_rgb_valid", rgb_valid, 0);
        check_output("midreset_err", err, 0);
        check_output("midreset_frame_done", frame_done, 0);
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 5);
        rst_n = 1'b1;
        send_word(24'hFFFFFF);
        apply_stimulus(1'b0, 2600);
        check_output("err_count_after_reset", err_seen, 3);
        check_output("rgb_after_reset", rgb, 0);

        check_output("rgb_queue_drained", rgb_exp_q.size(), 0);
        check_output("frame_queue_drained", fd_pix_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
